// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - serial-in parallel-out frame deserializer with start-marker resync
module sipo_deser #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_POS = IW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  // Bit 0 of a frame lands at the top of the word when MSB_FIRST is set.
  localparam logic [IW-1:0] FIRST_POS = (MSB_FIRST != 0) ? LAST_POS : '0;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_next;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_out_next;
  logic             r_out_valid;
  logic             w_out_valid_next;
  logic             r_frame_err;
  logic             w_frame_err_next;
  logic [IW-1:0]    w_idx;
  logic [IW-1:0]    w_pos;
  logic [WIDTH-1:0] w_fresh;
  logic [WIDTH-1:0] w_merged;

  // Map the running bit index onto its word position and build candidate words.
  always_comb begin
    w_idx    = r_cnt[IW-1:0];
    w_pos    = (MSB_FIRST != 0) ? (LAST_POS - w_idx) : w_idx;
    w_fresh  = '0;
    w_fresh[FIRST_POS] = in;
    w_merged = r_sr;
    w_merged[w_pos] = in;
  end

  // Next-state and next-register logic; pulses default low so they last one cycle.
  always_comb begin
    w_next_state     = r_state;
    w_cnt_next       = r_cnt;
    w_sr_next        = r_sr;
    w_out_next       = r_out;
    w_out_valid_next = 1'b0;
    w_frame_err_next = 1'b0;
    if (in_valid) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_sr_next    = w_fresh;
            w_cnt_next   = CW'(1);
            w_next_state = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (start) begin
            // Resync: drop the partial word, this bit opens a new frame.
            w_sr_next        = w_fresh;
            w_cnt_next       = CW'(1);
            w_frame_err_next = 1'b1;
          end else if (r_cnt == LAST_CNT) begin
            w_out_next       = w_merged;
            w_out_valid_next = 1'b1;
            w_sr_next        = '0;
            w_cnt_next       = '0;
            w_next_state     = S_IDLE;
          end else begin
            w_sr_next  = w_merged;
            w_cnt_next = r_cnt + CW'(1);
          end
        end
        default: begin
          w_next_state = S_IDLE;
          w_cnt_next   = '0;
          w_sr_next    = '0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_sr        <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_cnt_next;
      r_sr        <= w_sr_next;
      r_out       <= w_out_next;
      r_out_valid <= w_out_valid_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state == S_SHIFT);

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - self-checking bench for sipo_deser
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       sin = 1'b0;
  logic       start = 1'b0;
  logic [3:0] out_m, out_l;
  logic       ov_m, ov_l, busy_m, busy_l, fe_m, fe_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(sin), .start(start),
    .out(out_m), .out_valid(ov_m), .busy(busy_m), .frame_err(fe_m)
  );

  sipo_deser #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(sin), .start(start),
    .out(out_l), .out_valid(ov_l), .busy(busy_l), .frame_err(fe_l)
  );

  // Reference model: a list of bits received so far in the current frame.
  int         q[$];
  logic [3:0] m_out_m = '0;
  logic [3:0] m_out_l = '0;
  logic       m_ov = 1'b0;
  logic       m_fe = 1'b0;

  task automatic model_edge(input logic r, input logic v, input logic s, input logic b);
    m_ov = 1'b0;
    m_fe = 1'b0;
    if (!r) begin
      q.delete();
      m_out_m = '0;
      m_out_l = '0;
    end else if (v) begin
      if (s) begin
        m_fe = (q.size() > 0);
        q.delete();
        q.push_back(int'(b));
      end else if (q.size() > 0) begin
        q.push_back(int'(b));
        if (q.size() == 4) begin
          for (int k = 0; k < 4; k++) begin
            m_out_m[3-k] = q[k][0];
            m_out_l[k]   = q[k][0];
          end
          m_ov = 1'b1;
          q.delete();
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model and compare both DUTs against it.
  task automatic step(input logic r, input logic v, input logic s, input logic b);
    rst = r; in_valid = v; start = s; sin = b;
    @(posedge clk);
    model_edge(r, v, s, b);
    #1;
    chk("model_out_m", 32'(out_m), 32'(m_out_m));
    chk("model_out_l", 32'(out_l), 32'(m_out_l));
    chk("model_ov_m", 32'(ov_m), 32'(m_ov));
    chk("model_ov_l", 32'(ov_l), 32'(m_ov));
    chk("model_fe_m", 32'(fe_m), 32'(m_fe));
    chk("model_fe_l", 32'(fe_l), 32'(m_fe));
    chk("model_busy_m", 32'(busy_m), 32'(q.size() > 0));
    chk("model_busy_l", 32'(busy_l), 32'(q.size() > 0));
    chk("excl_ov_fe", 32'(ov_m & fe_m), 32'd0);
  endtask

  typedef struct {
    logic       r, v, s, b;
    logic [3:0] e_out;
    logic       e_ov, e_busy, e_fe;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic v, input logic s, input logic b,
                              input logic [3:0] eo, input logic eov, input logic eb, input logic efe);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.b = b;
    t.e_out = eo; t.e_ov = eov; t.e_busy = eb; t.e_fe = efe;
    return t;
  endfunction

  initial begin
    int pulses;
    int gap;
    logic [3:0] bits;

    // reset
    tbl.push_back(mk(0,0,0,0, 4'h0,0,0,0));
    // 1,0,1,1 MSB first -> 1011
    tbl.push_back(mk(1,1,1,1, 4'h0,0,1,0));
    tbl.push_back(mk(1,1,0,0, 4'h0,0,1,0));
    tbl.push_back(mk(1,1,0,1, 4'h0,0,1,0));
    tbl.push_back(mk(1,1,0,1, 4'hB,1,0,0));
    tbl.push_back(mk(1,0,0,0, 4'hB,0,0,0));
    // back-to-back 1010 then 0101
    tbl.push_back(mk(1,1,1,1, 4'hB,0,1,0));
    tbl.push_back(mk(1,1,0,0, 4'hB,0,1,0));
    tbl.push_back(mk(1,1,0,1, 4'hB,0,1,0));
    tbl.push_back(mk(1,1,0,0, 4'hA,1,0,0));
    tbl.push_back(mk(1,1,1,0, 4'hA,0,1,0));
    tbl.push_back(mk(1,1,0,1, 4'hA,0,1,0));
    tbl.push_back(mk(1,1,0,0, 4'hA,0,1,0));
    tbl.push_back(mk(1,1,0,1, 4'h5,1,0,0));
    // 1,1 then resync with 0,1,1,0
    tbl.push_back(mk(1,1,1,1, 4'h5,0,1,0));
    tbl.push_back(mk(1,1,0,1, 4'h5,0,1,0));
    tbl.push_back(mk(1,1,1,0, 4'h5,0,1,1));
    tbl.push_back(mk(1,1,0,1, 4'h5,0,1,0));
    tbl.push_back(mk(1,1,0,1, 4'h5,0,1,0));
    tbl.push_back(mk(1,1,0,0, 4'h6,1,0,0));
    // idle bit without start is discarded
    tbl.push_back(mk(1,1,0,1, 4'h6,0,0,0));
    // reset mid-frame, then 1100
    tbl.push_back(mk(1,1,1,1, 4'h6,0,1,0));
    tbl.push_back(mk(1,1,0,1, 4'h6,0,1,0));
    tbl.push_back(mk(0,1,0,1, 4'h0,0,0,0));
    tbl.push_back(mk(1,1,1,1, 4'h0,0,1,0));
    tbl.push_back(mk(1,1,0,1, 4'h0,0,1,0));
    tbl.push_back(mk(1,1,0,0, 4'h0,0,1,0));
    tbl.push_back(mk(1,1,0,0, 4'hC,1,0,0));
    // reset beats a start; first edge after reset accepts a frame
    tbl.push_back(mk(0,1,1,1, 4'h0,0,0,0));
    tbl.push_back(mk(1,1,1,0, 4'h0,0,1,0));
    tbl.push_back(mk(1,1,0,0, 4'h0,0,1,0));
    tbl.push_back(mk(1,1,0,1, 4'h0,0,1,0));
    tbl.push_back(mk(1,1,0,1, 4'h3,1,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].b);
      chk($sformatf("tbl%0d_out", i), 32'(out_m), 32'(tbl[i].e_out));
      chk($sformatf("tbl%0d_ov", i), 32'(ov_m), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_busy", i), 32'(busy_m), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_fe", i), 32'(fe_m), 32'(tbl[i].e_fe));
    end

    // 1,0,1,1 with random in_valid gaps between bits
    bits = 4'b1011;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step(1, 1, k == 0, bits[3-k]);
      pulses += int'(ov_m);
      if (k < 3) begin
        gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) begin
          step(1, 0, 0, 1'($urandom));
          pulses += int'(ov_m);
          chk("gap_busy", 32'(busy_m), 32'd1);
        end
      end
    end
    step(1, 0, 0, 0);
    pulses += int'(ov_m);
    chk("gap_out", 32'(out_m), 32'hB);
    chk("gap_pulses", 32'(pulses), 32'd1);

    // LSB-first 1,0,1,0 -> 0101
    bits = 4'b1010;
    for (int k = 0; k < 4; k++) step(1, 1, k == 0, bits[3-k]);
    chk("lsb_out", 32'(out_l), 32'h5);
    chk("lsb_ov", 32'(ov_l), 32'd1);

    // randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 5) == 0), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter WIDTH, default 4, frame length in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 = first received bit is out[WIDTH-1], 0 = first received bit is out[0].
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-005 in_valid  input  1  bit strobe; `in` is sampled only on edges where in_valid=1.
REQ-006 in  input  1  serial data bit, driven by the upstream PISO stage.
REQ-007 start  input  1  frame marker; qualifies the sampled bit as bit 0 of a new frame.
REQ-008 out  output  WIDTH  last completed parallel word, registered.
REQ-009 out_valid  output  1  one-cycle pulse marking a newly completed word on out.
REQ-010 busy  output  1  high while a frame is partially received.
REQ-011 frame_err  output  1  one-cycle pulse marking an aborted partial frame.

Function
REQ-012 Two-state FSM: IDLE, SHIFT; busy SHALL equal (state==SHIFT).
REQ-013 Internal bit counter cnt, width clog2(WIDTH+1); internal shift register sr[WIDTH-1:0], separate from out.
REQ-014 IDLE, in_valid=1 & start=1: sample in as bit 0, cnt<=1, next state SHIFT.
REQ-015 IDLE, in_valid=1 & start=0: bit discarded, state unchanged, no flag raised.
REQ-016 SHIFT, in_valid=1 & start=0: sample in at position cnt (ordering per MSB_FIRST), cnt<=cnt+1.
REQ-017 On the edge that samples bit WIDTH-1: out <= assembled word including that bit, out_valid=1 for the following cycle only, cnt<=0, next state IDLE.
REQ-018 Latency: out/out_valid valid in the cycle immediately after the edge sampling the last bit.
REQ-019 in_valid=0 in any state: hold state, cnt, sr, out; out_valid and frame_err return to 0.
REQ-020 SHIFT, in_valid=1 & start=1 (resync): discard partial word, frame_err=1 for the next cycle, sampled bit becomes bit 0 of a new frame, cnt<=1, stay SHIFT.
REQ-021 Resync SHALL NOT alter out or raise out_valid.
REQ-022 Back-to-back frames: start with in_valid on the cycle after completion SHALL be accepted with no dead cycle.
REQ-023 out SHALL hold its value between completions; no downstream handshake, a new word overwrites the previous one.
REQ-024 out_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-025 rst=0 at an edge: state IDLE, cnt=0, sr=0, out=0, out_valid=0, busy=0, frame_err=0.
REQ-026 rst has priority over in_valid/start; any partial frame is discarded with no out_valid or frame_err.
REQ-027 First frame SHALL be accepted on the first edge with rst=1.

Verification (WIDTH=4 unless stated)
REQ-028 MSB_FIRST=1, bits 1,0,1,1 on consecutive edges, start on first -> out=4'b1011, out_valid high exactly one cycle after the 4th edge, busy high for the 3 intervening cycles.
REQ-029 Same frame with in_valid=0 gaps of 1-3 cycles between bits -> identical out=4'b1011, single out_valid pulse, busy held through gaps.
REQ-030 MSB_FIRST=0, bits 1,0,1,0 -> out=4'b0101.
REQ-031 Back-to-back 1010 then 0101 with start on each bit 0 -> out=4'b1010 then 4'b0101, two out_valid pulses 4 cycles apart.
REQ-032 Two bits 1,1 then start with bits 0,1,1,0 -> frame_err pulse after the resync edge, out=4'b0110, prior out unchanged until completion.
REQ-033 rst=0 after 2 bits of a frame -> all outputs 0, no out_valid; next full frame 1100 completes normally -> out=4'b1100.
